// File: rtl/hazard_pkg.sv
// Shared types and helpers for the multi-cycle hazard unit.
// Latency: none; these are type definitions and one pure function.
// Backpressure: not applicable.
package hazard_pkg;

  // Operand source select for the EX-stage operand muxes.
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10
  } fwd_sel_e;

  // IDLE: no outstanding data-memory access blocking the pipe.
  // MEM_WAIT: the MEM-stage access is still waiting for its response.
  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  // True when a stage that writes rd produces the register named by rs.
  // x0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic reg_hit(input logic [4:0] rd,
                                   input logic       wren,
                                   input logic [4:0] rs);
    return wren && (rd != REG_X0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_unit_mc_fwd_select.sv
// Forwarding select for one EX operand: MEM result first, then WB, else RF.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller holds the pipeline when operands are frozen.
//
// Ports:
//   rs                 EX-stage source register of this operand
//   m_rd, m_regwren    MEM-stage destination and write enable
//   w_rd, w_regwren    WB-stage destination and write enable
//   sel                chosen operand source
module fwd_select
  import hazard_pkg::*;
#(
  parameter int unsigned FWD_EN = 1
) (
  input  logic [4:0] rs,
  input  logic [4:0] m_rd,
  input  logic       m_regwren,
  input  logic [4:0] w_rd,
  input  logic       w_regwren,
  output fwd_sel_e   sel
);

  // MEM holds the younger result, so it takes priority over WB.
  always_comb begin
    sel = FWD_NONE;
    if (FWD_EN != 0) begin
      if (reg_hit(m_rd, m_regwren, rs)) begin
        sel = FWD_MEM;
      end else if (reg_hit(w_rd, w_regwren, rs)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit: RAW stalls, branch flushes, forwarding, memory waits.
// Latency: all pipeline controls are combinational (zero cycles); counters/err registered.
// Backpressure: an unanswered MEM access freezes IF..EX/MEM and bubbles MEM/WB.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   d_rs1, d_rs2                   ID-stage sources
//   e_rs1, e_rs2, e_rd             EX-stage registers; e_memren/e_regwren controls
//   m_rd, m_rs2                    MEM-stage registers; m_regwren/m_memren/m_memwren
//   w_rd, w_regwren                WB writeback
//   e_br_taken                     EX redirect (branch or jump)
//   dmem_rsp_valid                 data memory completes the current MEM access
//   stall_if .. memwb_flush        pipeline register enables / flushes
//   rs1_sel, rs2_sel, wm_fwd_sel   forwarding selects
//   perf_stall_cnt, perf_flush_cnt saturating event counters
//   timeout_err                    sticky memory-wait timeout flag
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int unsigned FWD_EN    = 1,
  parameter int unsigned RF_BYPASS = 0,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       d_rs1,
  input  logic [4:0]       d_rs2,
  input  logic [4:0]       e_rs1,
  input  logic [4:0]       e_rs2,
  input  logic [4:0]       e_rd,
  input  logic             e_memren,
  input  logic             e_regwren,
  input  logic [4:0]       m_rd,
  input  logic [4:0]       m_rs2,
  input  logic             m_regwren,
  input  logic             m_memren,
  input  logic             m_memwren,
  input  logic [4:0]       w_rd,
  input  logic             w_regwren,
  input  logic             e_br_taken,
  input  logic             dmem_rsp_valid,
  output logic             stall_if,
  output logic             ifid_wren,
  output logic             ifid_flush,
  output logic             idex_wren,
  output logic             idex_flush,
  output logic             exmem_wren,
  output logic             memwb_flush,
  output logic [1:0]       rs1_sel,
  output logic [1:0]       rs2_sel,
  output logic             wm_fwd_sel,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt,
  output logic             timeout_err
);

  localparam int unsigned WAIT_W      = $clog2(TIMEOUT + 1);
  localparam bit          FWD_ON      = (FWD_EN != 0);
  localparam bit          WB_STALL_ON = (RF_BYPASS == 0);

  hz_state_e   state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_inc;
  logic        wait_at_max;

  logic mem_req;
  logic mem_stall;
  logic load_use_hz;
  logic wb_id_hz;
  logic ex_raw_hz;
  logic mem_raw_hz;
  logic hz_stall;

  fwd_sel_e rs1_fwd;
  fwd_sel_e rs2_fwd;

  // A response in the request cycle never stalls, whatever the FSM state.
  assign mem_req   = m_memren | m_memwren;
  assign mem_stall = mem_req & ~dmem_rsp_valid;

  // The load result only exists after MEM, so a consumer in ID must wait
  // one cycle even with forwarding.
  assign load_use_hz = reg_hit(e_rd, e_memren, d_rs1) | reg_hit(e_rd, e_memren, d_rs2);

  // Without a write-before-read register file, ID would read a stale value
  // for the register WB is writing this cycle.
  assign wb_id_hz = WB_STALL_ON &
                    (reg_hit(w_rd, w_regwren, d_rs1) | reg_hit(w_rd, w_regwren, d_rs2));

  // With forwarding disabled every in-flight producer blocks its consumer.
  assign ex_raw_hz  = ~FWD_ON &
                      (reg_hit(e_rd, e_regwren, d_rs1) | reg_hit(e_rd, e_regwren, d_rs2));
  assign mem_raw_hz = ~FWD_ON &
                      (reg_hit(m_rd, m_regwren, d_rs1) | reg_hit(m_rd, m_regwren, d_rs2));

  assign hz_stall = load_use_hz | wb_id_hz | ex_raw_hz | mem_raw_hz;

  fwd_select #(.FWD_EN(FWD_EN)) u_fwd_rs1 (
    .rs        (e_rs1),
    .m_rd      (m_rd),
    .m_regwren (m_regwren),
    .w_rd      (w_rd),
    .w_regwren (w_regwren),
    .sel       (rs1_fwd)
  );

  fwd_select #(.FWD_EN(FWD_EN)) u_fwd_rs2 (
    .rs        (e_rs2),
    .m_rd      (m_rd),
    .m_regwren (m_regwren),
    .w_rd      (w_rd),
    .w_regwren (w_regwren),
    .sel       (rs2_fwd)
  );

  assign rs1_sel = rs1_fwd;
  assign rs2_sel = rs2_fwd;

  // Store data in MEM comes from the instruction retiring in WB.
  assign wm_fwd_sel = FWD_ON & m_memwren & reg_hit(w_rd, w_regwren, m_rs2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus pipeline controls. A memory wait freezes everything up
  // to EX/MEM, so a taken branch sitting in EX stays put and its flush is
  // applied naturally on the release cycle, when mem_stall drops.
  always_comb begin
    state_d     = state_q;
    stall_if    = 1'b0;
    ifid_wren   = 1'b1;
    ifid_flush  = 1'b0;
    idex_wren   = 1'b1;
    idex_flush  = 1'b0;
    exmem_wren  = 1'b1;
    memwb_flush = 1'b0;

    case (state_q)
      IDLE:     if (mem_stall)      state_d = MEM_WAIT;
      MEM_WAIT: if (dmem_rsp_valid) state_d = IDLE;
      default:                      state_d = IDLE;
    endcase

    if (mem_stall) begin
      stall_if    = 1'b1;
      ifid_wren   = 1'b0;
      idex_wren   = 1'b0;
      exmem_wren  = 1'b0;
      memwb_flush = 1'b1;
    end else begin
      if (hz_stall) begin
        // Hold IF/ID, let a bubble into ID/EX, keep the older stages moving.
        stall_if   = 1'b1;
        ifid_wren  = 1'b0;
        idex_flush = 1'b1;
      end
      if (e_br_taken) begin
        // The stalled ID instruction is on the wrong path anyway: squash it
        // and let the fetch redirect proceed.
        stall_if   = 1'b0;
        ifid_wren  = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  // Counts MEM_WAIT cycles without a response. The FSM keeps waiting after
  // a timeout; the error flag is the only escalation.
  assign wait_at_max = (wait_cnt == WAIT_W'(TIMEOUT));
  assign wait_inc    = wait_cnt + WAIT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else if (state_q == IDLE || dmem_rsp_valid) begin
      wait_cnt <= '0;
    end else if (!wait_at_max) begin
      wait_cnt <= wait_inc;
      if (wait_inc == WAIT_W'(TIMEOUT)) begin
        timeout_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_if && (perf_stall_cnt != {CNT_W{1'b1}})) begin
        perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      end
      if (ifid_flush && (perf_flush_cnt != {CNT_W{1'b1}})) begin
        perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: two configurations share one stimulus stream.
// Latency: expected values are checked in the same cycle the inputs are applied.
// Backpressure: not applicable.
module tb_hazard_unit_mc;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] d_rs1, d_rs2, e_rs1, e_rs2, e_rd, m_rd, m_rs2, w_rd;
    logic e_memren, e_regwren, m_regwren, m_memren, m_memwren, w_regwren, br, rsp;
  } in_t;

  typedef struct packed {
    logic stall_if, ifid_wren, ifid_flush, idex_wren, idex_flush, exmem_wren, memwb_flush;
    logic [1:0] rs1_sel, rs2_sel;
    logic wm;
    logic [31:0] ps, pf;
    logic err;
    logic in_wait;
  } out_t;

  typedef struct {
    bit     in_wait;
    int     waited;
    bit     err;
    longint ps, pf;
  } ms_t;

  typedef struct {
    int     cyc;
    out_t   a, b;
    int     dsel;
    longint dexp;
  } exp_t;

  localparam int D_NONE = 0, D_A_STALL = 1, D_A_PS = 2, D_A_RS1 = 3, D_B_RS1 = 4,
                 D_B_STALL = 5, D_B_RS2 = 6, D_A_RS2 = 7, D_A_WM = 8, D_A_IFID_FL = 9,
                 D_B_ERR = 10, D_B_PS = 11, D_A_MEMWB = 12, D_A_WAIT = 13;

  in_t vin = '0;
  exp_t sbq[$];
  ms_t ma, mb;
  int cyc_no = 0;
  int n_total = 0;
  int n_pass = 0;

  logic a_stall_if, a_ifid_wren, a_ifid_flush, a_idex_wren, a_idex_flush, a_exmem_wren;
  logic a_memwb_flush, a_wm, a_err;
  logic [1:0] a_rs1_sel, a_rs2_sel;
  logic [31:0] a_ps, a_pf;
  logic b_stall_if, b_ifid_wren, b_ifid_flush, b_idex_wren, b_idex_flush, b_exmem_wren;
  logic b_memwb_flush, b_wm, b_err;
  logic [1:0] b_rs1_sel, b_rs2_sel;
  logic [3:0] b_ps, b_pf;

  hazard_unit_mc #(.FWD_EN(1), .RF_BYPASS(0), .TIMEOUT(64), .CNT_W(32)) u_a (
    .clk(clk), .rst_n(rst_n),
    .d_rs1(vin.d_rs1), .d_rs2(vin.d_rs2), .e_rs1(vin.e_rs1), .e_rs2(vin.e_rs2), .e_rd(vin.e_rd),
    .e_memren(vin.e_memren), .e_regwren(vin.e_regwren), .m_rd(vin.m_rd), .m_rs2(vin.m_rs2),
    .m_regwren(vin.m_regwren), .m_memren(vin.m_memren), .m_memwren(vin.m_memwren),
    .w_rd(vin.w_rd), .w_regwren(vin.w_regwren), .e_br_taken(vin.br), .dmem_rsp_valid(vin.rsp),
    .stall_if(a_stall_if), .ifid_wren(a_ifid_wren), .ifid_flush(a_ifid_flush),
    .idex_wren(a_idex_wren), .idex_flush(a_idex_flush), .exmem_wren(a_exmem_wren),
    .memwb_flush(a_memwb_flush), .rs1_sel(a_rs1_sel), .rs2_sel(a_rs2_sel), .wm_fwd_sel(a_wm),
    .perf_stall_cnt(a_ps), .perf_flush_cnt(a_pf), .timeout_err(a_err)
  );

  hazard_unit_mc #(.FWD_EN(0), .RF_BYPASS(1), .TIMEOUT(4), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .d_rs1(vin.d_rs1), .d_rs2(vin.d_rs2), .e_rs1(vin.e_rs1), .e_rs2(vin.e_rs2), .e_rd(vin.e_rd),
    .e_memren(vin.e_memren), .e_regwren(vin.e_regwren), .m_rd(vin.m_rd), .m_rs2(vin.m_rs2),
    .m_regwren(vin.m_regwren), .m_memren(vin.m_memren), .m_memwren(vin.m_memwren),
    .w_rd(vin.w_rd), .w_regwren(vin.w_regwren), .e_br_taken(vin.br), .dmem_rsp_valid(vin.rsp),
    .stall_if(b_stall_if), .ifid_wren(b_ifid_wren), .ifid_flush(b_ifid_flush),
    .idex_wren(b_idex_wren), .idex_flush(b_idex_flush), .exmem_wren(b_exmem_wren),
    .memwb_flush(b_memwb_flush), .rs1_sel(b_rs1_sel), .rs2_sel(b_rs2_sel), .wm_fwd_sel(b_wm),
    .perf_stall_cnt(b_ps), .perf_flush_cnt(b_pf), .timeout_err(b_err)
  );

  // ---------------- reference model ----------------
  function automatic bit writes(logic [4:0] rd, logic we, logic [4:0] a, logic [4:0] b);
    return we && rd != 0 && (rd == a || rd == b);
  endfunction

  function automatic logic [1:0] pick(in_t i, bit fwd, logic [4:0] rs);
    if (!fwd) return 2'd0;
    if (i.m_regwren && i.m_rd != 0 && i.m_rd == rs) return 2'd1;
    if (i.w_regwren && i.w_rd != 0 && i.w_rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  function automatic out_t expect_out(in_t i, bit fwd, bit byp, ms_t s);
    out_t o;
    bit hz, mstall;
    mstall = (i.m_memren || i.m_memwren) && !i.rsp;
    hz = writes(i.e_rd, i.e_memren, i.d_rs1, i.d_rs2)
       || (!byp && writes(i.w_rd, i.w_regwren, i.d_rs1, i.d_rs2))
       || (!fwd && (writes(i.e_rd, i.e_regwren, i.d_rs1, i.d_rs2)
                 || writes(i.m_rd, i.m_regwren, i.d_rs1, i.d_rs2)));
    o = '0;
    if (mstall) begin
      o.stall_if = 1; o.memwb_flush = 1;
    end else begin
      o.stall_if   = hz && !i.br;
      o.ifid_wren  = !o.stall_if;
      o.ifid_flush = i.br;
      o.idex_flush = hz || i.br;
      o.idex_wren  = 1;
      o.exmem_wren = 1;
    end
    o.rs1_sel = pick(i, fwd, i.e_rs1);
    o.rs2_sel = pick(i, fwd, i.e_rs2);
    o.wm      = fwd && i.m_memwren && i.w_regwren && i.w_rd != 0 && i.w_rd == i.m_rs2;
    o.ps      = s.ps[31:0];
    o.pf      = s.pf[31:0];
    o.err     = s.err;
    o.in_wait = s.in_wait;
    return o;
  endfunction

  function automatic ms_t step(in_t i, int to, longint lim, ms_t s, out_t o);
    ms_t n = s;
    if (!s.in_wait) begin
      n.waited  = 0;
      n.in_wait = (i.m_memren || i.m_memwren) && !i.rsp;
    end else if (i.rsp) begin
      n.in_wait = 0;
      n.waited  = 0;
    end else begin
      if (s.waited < to) n.waited = s.waited + 1;
      if (n.waited >= to) n.err = 1;
    end
    if (o.stall_if && s.ps < lim) n.ps = s.ps + 1;
    if (o.ifid_flush && s.pf < lim) n.pf = s.pf + 1;
    return n;
  endfunction

  function automatic ms_t ms_zero();
    ms_t z;
    z.in_wait = 0; z.waited = 0; z.err = 0; z.ps = 0; z.pf = 0;
    return z;
  endfunction

  // ---------------- stimulus ----------------
  task automatic cyc(input in_t i, input bit r, input int dsel, input longint dexp);
    exp_t e;
    @(posedge clk); #1;
    vin   = i;
    rst_n = r;
    if (!r) begin
      ma = ms_zero();
      mb = ms_zero();
    end
    cyc_no++;
    e.cyc  = cyc_no;
    e.a    = expect_out(i, 1'b1, 1'b0, ma);
    e.b    = expect_out(i, 1'b0, 1'b1, mb);
    e.dsel = dsel;
    e.dexp = dexp;
    sbq.push_back(e);
    if (r) begin
      ma = step(i, 64, 64'hFFFF_FFFF, ma, e.a);
      mb = step(i, 4, 64'd15, mb, e.b);
    end
  endtask

  function automatic in_t rand_in();
    in_t v;
    v.d_rs1 = 5'($urandom_range(0, 7)); v.d_rs2 = 5'($urandom_range(0, 7));
    v.e_rs1 = 5'($urandom_range(0, 7)); v.e_rs2 = 5'($urandom_range(0, 7));
    v.e_rd  = 5'($urandom_range(0, 7)); v.m_rd  = 5'($urandom_range(0, 7));
    v.m_rs2 = 5'($urandom_range(0, 7)); v.w_rd  = 5'($urandom_range(0, 7));
    v.e_memren  = ($urandom_range(0, 2) == 0);
    v.e_regwren = ($urandom_range(0, 1) == 0);
    v.m_regwren = ($urandom_range(0, 1) == 0);
    v.m_memren  = ($urandom_range(0, 2) == 0);
    v.m_memwren = ($urandom_range(0, 3) == 0);
    v.w_regwren = ($urandom_range(0, 1) == 0);
    v.br        = ($urandom_range(0, 3) == 0);
    v.rsp       = ($urandom_range(0, 3) != 0);
    return v;
  endfunction

  initial begin
    in_t idle, v;
    idle = '0;
    ma = ms_zero();
    mb = ms_zero();

    // Reset state.
    cyc(idle, 0, D_A_PS, 0);
    cyc(idle, 0, D_B_ERR, 0);
    cyc(idle, 1, D_NONE, 0);

    // Load-use: one stall cycle, counter 0 -> 1.
    v = '0; v.e_memren = 1; v.e_rd = 5; v.d_rs1 = 5;
    cyc(v, 1, D_A_STALL, 1);
    cyc(idle, 1, D_A_PS, 1);

    // Forwarding priority MEM > WB > none.
    v = '0; v.e_rs1 = 7; v.m_rd = 7; v.m_regwren = 1; v.w_rd = 7; v.w_regwren = 1;
    cyc(v, 1, D_A_RS1, 1);
    cyc(v, 1, D_B_RS1, 0);
    v.m_regwren = 0;
    cyc(v, 1, D_A_RS1, 2);
    v.e_rs1 = 0;
    cyc(v, 1, D_A_RS1, 0);

    // No forwarding: EX producer stalls ID and selects stay 00.
    v = '0; v.e_rd = 3; v.e_regwren = 1; v.d_rs2 = 3; v.e_rs2 = 3; v.m_rd = 3; v.m_regwren = 1;
    cyc(v, 1, D_B_STALL, 1);
    cyc(v, 1, D_B_RS2, 0);
    cyc(v, 1, D_A_RS2, 1);
    cyc(v, 1, D_A_STALL, 0);

    // WB-to-MEM store data forward.
    v = '0; v.m_memwren = 1; v.m_rs2 = 9; v.w_rd = 9; v.w_regwren = 1; v.rsp = 1;
    cyc(v, 1, D_A_WM, 1);

    // Memory wait with a deferred branch.
    cyc(idle, 0, D_NONE, 0);
    cyc(idle, 1, D_NONE, 0);
    v = '0; v.m_memren = 1; v.br = 1;
    cyc(v, 1, D_A_IFID_FL, 0);
    cyc(v, 1, D_A_WAIT, 1);
    cyc(v, 1, D_A_MEMWB, 1);
    v.rsp = 1;
    cyc(v, 1, D_A_IFID_FL, 1);
    cyc(idle, 1, D_A_WAIT, 0);

    // Reset in the middle of a wait abandons it.
    v = '0; v.m_memren = 1;
    cyc(v, 1, D_NONE, 0);
    cyc(v, 1, D_NONE, 0);
    cyc(v, 0, D_A_WAIT, 0);
    cyc(idle, 1, D_A_WAIT, 0);

    // Timeout (config B, TIMEOUT=4): sticky until reset.
    v = '0; v.m_memren = 1;
    for (int k = 1; k <= 8; k++) begin
      cyc(v, 1, (k == 5) ? D_B_ERR : ((k == 6) ? D_B_ERR : D_NONE), (k == 6) ? 1 : 0);
    end
    v.rsp = 1;
    cyc(v, 1, D_B_ERR, 1);
    cyc(idle, 1, D_B_ERR, 1);
    cyc(idle, 0, D_B_ERR, 0);
    cyc(idle, 1, D_NONE, 0);

    // 20 stall cycles: 4-bit counter saturates at 15, 32-bit reaches 20.
    v = '0; v.e_memren = 1; v.e_rd = 5; v.d_rs1 = 5;
    for (int k = 0; k < 20; k++) cyc(v, 1, D_NONE, 0);
    cyc(idle, 1, D_B_PS, 15);
    cyc(idle, 1, D_A_PS, 20);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      cyc(rand_in(), ($urandom_range(0, 399) != 0), D_NONE, 0);
    end

    cyc(idle, 1, D_NONE, 0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // ---------------- monitor / scoreboard ----------------
  exp_t   me;
  out_t   ga, gb;
  longint dact;
  string  dname;

  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      me = sbq.pop_front();
      ga = '0; gb = '0;
      ga.stall_if = a_stall_if; ga.ifid_wren = a_ifid_wren; ga.ifid_flush = a_ifid_flush;
      ga.idex_wren = a_idex_wren; ga.idex_flush = a_idex_flush; ga.exmem_wren = a_exmem_wren;
      ga.memwb_flush = a_memwb_flush; ga.rs1_sel = a_rs1_sel; ga.rs2_sel = a_rs2_sel;
      ga.wm = a_wm; ga.ps = a_ps; ga.pf = a_pf; ga.err = a_err;
      ga.in_wait = (u_a.state_q == MEM_WAIT);
      gb.stall_if = b_stall_if; gb.ifid_wren = b_ifid_wren; gb.ifid_flush = b_ifid_flush;
      gb.idex_wren = b_idex_wren; gb.idex_flush = b_idex_flush; gb.exmem_wren = b_exmem_wren;
      gb.memwb_flush = b_memwb_flush; gb.rs1_sel = b_rs1_sel; gb.rs2_sel = b_rs2_sel;
      gb.wm = b_wm; gb.ps = {28'd0, b_ps}; gb.pf = {28'd0, b_pf}; gb.err = b_err;
      gb.in_wait = (u_b.state_q == MEM_WAIT);

      n_total++;
      if (ga === me.a) n_pass++;
      else $display("FAIL cfg_a cycle %0d: got %h, expected %h", me.cyc, ga, me.a);
      n_total++;
      if (gb === me.b) n_pass++;
      else $display("FAIL cfg_b cycle %0d: got %h, expected %h", me.cyc, gb, me.b);

      if (me.dsel != D_NONE) begin
        case (me.dsel)
          D_A_STALL:   begin dact = longint'(a_stall_if);    dname = "a_stall_if"; end
          D_A_PS:      begin dact = longint'(a_ps);          dname = "a_perf_stall_cnt"; end
          D_A_RS1:     begin dact = longint'(a_rs1_sel);     dname = "a_rs1_sel"; end
          D_B_RS1:     begin dact = longint'(b_rs1_sel);     dname = "b_rs1_sel"; end
          D_B_STALL:   begin dact = longint'(b_stall_if);    dname = "b_stall_if"; end
          D_B_RS2:     begin dact = longint'(b_rs2_sel);     dname = "b_rs2_sel"; end
          D_A_RS2:     begin dact = longint'(a_rs2_sel);     dname = "a_rs2_sel"; end
          D_A_WM:      begin dact = longint'(a_wm);          dname = "a_wm_fwd_sel"; end
          D_A_IFID_FL: begin dact = longint'(a_ifid_flush);  dname = "a_ifid_flush"; end
          D_B_ERR:     begin dact = longint'(b_err);         dname = "b_timeout_err"; end
          D_B_PS:      begin dact = longint'(b_ps);          dname = "b_perf_stall_cnt"; end
          D_A_MEMWB:   begin dact = longint'(a_memwb_flush); dname = "a_memwb_flush"; end
          D_A_WAIT:    begin dact = (u_a.state_q == MEM_WAIT) ? 1 : 0; dname = "a_mem_wait"; end
          default:     begin dact = -1;                      dname = "unknown"; end
        endcase
        n_total++;
        if (dact == me.dexp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d, expected %0d", dname, me.cyc, dact, me.dexp);
      end
    end
  end

endmodule
